// File: rtl/frame_buffer_pingpong.sv
// Double-buffered camera frame store: the camera stream fills one bank while the reader
// fetches single pixels or whole blocks from the other; banks swap on completed frames.
module frame_buffer_pingpong #(
   parameter int PIXEL_W      = 8,
   parameter int BLOCK_PIXELS = 16,
   parameter int FRAME_PIXELS = 131072,
   parameter int ADDR_W       = $clog2(FRAME_PIXELS),
   parameter int BLK_ADDR_W   = $clog2(FRAME_PIXELS / BLOCK_PIXELS)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             wrValid,
   input  logic                             wrSof,
   input  logic [PIXEL_W-1:0]               wrPixel,
   input  logic                             rdHold,
   input  logic                             rdEn,
   input  logic [ADDR_W-1:0]                rdByteAddr,
   input  logic [BLK_ADDR_W-1:0]            rdBlockAddr,
   output logic [PIXEL_W-1:0]               pixelOut,
   output logic [PIXEL_W*BLOCK_PIXELS-1:0]  pixelBlockOut,
   output logic                             rdValid,
   output logic                             rdBank,
   output logic [15:0]                      frameCount,
   output logic [15:0]                      dropCount
);

   localparam int ROWS   = FRAME_PIXELS / BLOCK_PIXELS;
   localparam int LANE_W = $clog2(BLOCK_PIXELS);
   localparam int IDX_W  = BLK_ADDR_W + 1;
   localparam int BLK_W  = PIXEL_W * BLOCK_PIXELS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, WRITE, PENDING} wrState_t;

   wrState_t          state, stateNext;
   logic [ADDR_W-1:0] wrPtr, wrPtrNext, memAddr;
   logic              memWe, doSwap, doDrop;

   // Each bank is split into BLOCK_PIXELS lanes so a whole block is one row across all lanes.
   function automatic logic [IDX_W-1:0] bankIdx(input logic bank, input logic [BLK_ADDR_W-1:0] row);
      return bank ? IDX_W'(ROWS) + {1'b0, row} : {1'b0, row};
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         wrPtr <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples
         // pre-edge values, independent of block ordering.
         state <= stateNext;
         wrPtr <= wrPtrNext;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      stateNext = state;
      wrPtrNext = wrPtr;
      memWe     = 1'b0;
      memAddr   = wrPtr;
      doSwap    = 1'b0;
      doDrop    = 1'b0;
      unique case (state)
         IDLE: begin
            if (wrValid && wrSof) begin
               memWe     = 1'b1;
               memAddr   = '0;
               wrPtrNext = ADDR_W'(1);
               stateNext = WRITE;
            end
         end
         WRITE: begin
            if (wrValid) begin
               memWe = 1'b1;
               if (wrSof) begin
                  memAddr   = '0;
                  wrPtrNext = ADDR_W'(1);
               end else if (wrPtr == LAST_ADDR) begin
                  wrPtrNext = '0;
                  if (!rdHold) begin
                     doSwap    = 1'b1;
                     stateNext = IDLE;
                  end else begin
                     stateNext = PENDING;
                  end
               end else begin
                  wrPtrNext = wrPtr + ADDR_W'(1);
               end
            end
         end
         PENDING: begin
            // A complete frame is parked; nothing new can land until the reader lets go.
            doDrop = wrValid;
            if (!rdHold) begin
               doSwap    = 1'b1;
               wrPtrNext = '0;
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdBank     <= 1'b1;
         frameCount <= '0;
         dropCount  <= '0;
      end else begin
         if (doSwap) begin
            rdBank     <= ~rdBank;
            frameCount <= frameCount + 16'd1;
         end
         if (doDrop && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
      end
   end

   logic [LANE_W-1:0]                    wrLane;
   logic [IDX_W-1:0]                     wrIdx, byteIdx, blkIdx;
   logic [BLOCK_PIXELS-1:0][PIXEL_W-1:0] laneByte, laneBlk;

   assign wrLane  = memAddr[LANE_W-1:0];
   assign wrIdx   = bankIdx(~rdBank, memAddr[ADDR_W-1:LANE_W]);
   assign byteIdx = bankIdx(rdBank, rdByteAddr[ADDR_W-1:LANE_W]);
   assign blkIdx  = bankIdx(rdBank, rdBlockAddr);

   for (genvar lane = 0; lane < BLOCK_PIXELS; lane++) begin : gLane
      logic [PIXEL_W-1:0] laneMem [2*ROWS];

      // NOTE: pixel storage has no reset; contents are undefined until written, which keeps it RAM-mappable.
      always_ff @(posedge clk) begin
         if (memWe && wrLane == LANE_W'(lane)) laneMem[wrIdx] <= wrPixel;
      end

      assign laneByte[lane] = laneMem[byteIdx];
      assign laneBlk[lane]  = laneMem[blkIdx];
   end

   logic             byteInRange;
   logic [BLK_W-1:0] blockWord;

   assign byteInRange = {1'b0, rdByteAddr} < (ADDR_W + 1)'(FRAME_PIXELS);

   // Pixel 0 of the block sits in the most significant slot.
   always_comb begin
      blockWord = '0;
      for (int i = 0; i < BLOCK_PIXELS; i++) begin
         blockWord[BLK_W-1-i*PIXEL_W -: PIXEL_W] = laneBlk[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdValid       <= 1'b0;
         pixelOut      <= '0;
         pixelBlockOut <= '0;
      end else begin
         rdValid <= rdEn;
         if (rdEn) begin
            pixelOut      <= byteInRange ? laneByte[rdByteAddr[LANE_W-1:0]] : '0;
            pixelBlockOut <= blockWord;
         end
      end
   end

endmodule

// File: doc/frame_buffer_pingpong.md
# frame_buffer_pingpong

Parametrised double-buffered camera frame store; the next generation of our single-frame pixel memory. A sequential pixel stream from the camera capture path is written into one bank while the display/processing side reads the other bank, either one pixel or one block of pixels at a time. Banks swap only on a completed frame and only when the reader is not holding its bank.

## Interface
- PIXEL_W, 8, bits per pixel
- BLOCK_PIXELS, 16, pixels per block read (power of 2, ≥2)
- FRAME_PIXELS, 131072, pixels per frame (multiple of BLOCK_PIXELS)
- ADDR_W, clog2(FRAME_PIXELS), pixel address width (derived)
- BLK_ADDR_W, clog2(FRAME_PIXELS/BLOCK_PIXELS), block address width (derived)
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high
- wrValid  in  1  wrPixel valid this cycle
- wrSof  in  1  qualifies wrValid: this pixel is frame pixel 0
- wrPixel  in  PIXEL_W  camera pixel
- rdHold  in  1  reader owns its bank; blocks swap while high
- rdEn  in  1  read request
- rdByteAddr  in  ADDR_W  pixel address for pixelOut
- rdBlockAddr  in  BLK_ADDR_W  block address for pixelBlockOut
- pixelOut  out  PIXEL_W  pixel at rdByteAddr
- pixelBlockOut  out  PIXEL_W*BLOCK_PIXELS  block at rdBlockAddr
- rdValid  out  1  outputs valid (one cycle after rdEn)
- rdBank  out  1  bank currently readable
- frameCount  out  16  completed swaps, wraps
- dropCount  out  16  pixels dropped while PENDING, saturates at 0xFFFF

## Operation
- Two banks of FRAME_PIXELS × PIXEL_W. Writer always targets wrBank = ~rdBank; no read/write collision possible.
- Write FSM states IDLE, WRITE, PENDING; write pointer wrPtr (ADDR_W).
- IDLE: wrValid&wrSof → store pixel at address 0, wrPtr=1, go WRITE. wrValid without wrSof ignored (not counted).
- WRITE: wrValid&wrSof → restart: store at 0, wrPtr=1 (partial frame abandoned, no swap). wrValid&~wrSof → store at wrPtr, wrPtr+1. Store to address FRAME_PIXELS-1 completes the frame: if rdHold=0 same cycle → swap, go IDLE; else go PENDING.
- PENDING: every wrValid (any wrSof) dropped, dropCount+1 saturating. rdHold=0 → swap, go IDLE (a pixel arriving in that cycle is dropped and counted).
- Swap: rdBank toggles, frameCount+1, wrPtr=0.
- Read: rdEn registers both lookups from rdBank as sampled in the request cycle. pixelOut = bank[rdByteAddr]. pixelBlockOut = bank[rdBlockAddr*BLOCK_PIXELS + i] for i=0..BLOCK_PIXELS-1, pixel i=0 in MS bits [PIXEL_W*BLOCK_PIXELS-1 -: PIXEL_W]. rdByteAddr ≥ FRAME_PIXELS returns 0.
- pixelOut/pixelBlockOut hold their last value when rdEn=0.

## Timing
- Reset values: state IDLE, wrPtr 0, rdBank 1, rdValid 0, pixelOut 0, pixelBlockOut 0, frameCount 0, dropCount 0. Memory contents not reset (undefined until written).
- Read latency 1 cycle: rdEn at edge N → data and rdValid=1 after edge N+1; rdValid=0 after any edge with rdEn=0. Back-to-back reads every cycle supported.
- Swap takes effect at the edge that stores the final pixel (or the edge where rdHold is seen low in PENDING); rdEn in that same cycle reads the old bank; rdEn next cycle reads the new bank.
- Write of the last pixel and swap cost no extra cycles; next frame's wrSof may arrive the very next cycle and is accepted.
- reset mid-frame: immediate return to IDLE, rdBank=1, counters cleared; partial data discarded.
- wrPtr wrap: never increments past FRAME_PIXELS-1; completion forces 0.

## Test plan
- Params FRAME_PIXELS=64, BLOCK_PIXELS=16. Reset, write frame pixels 0..63 (value=addr), rdHold=0 → after last pixel rdBank=0, frameCount=1; rdEn byte 37 → pixelOut=0x25 one cycle later, rdValid=1.
- Block read rdBlockAddr=2 → pixelBlockOut MS byte 0x20 … LS byte 0x2F.
- rdHold=1 across frame end, send 5 more pixels → no swap, dropCount=5, reads still return old bank; drop rdHold → swap next edge, frameCount increments.
- wrSof mid-frame at pixel 30 then full 64-pixel frame → only one swap, data equals second frame.
- Pixels without wrSof after reset ignored: 10 pixels then valid frame → stored frame starts at the wrSof pixel.
- Assert reset at pixel 40 of second frame → rdBank=1, frameCount=0, dropCount=0, rdValid=0 immediately.
